// File: rtl/plat_collide_scan_pkg.sv
// Shared parameters, state encoding and result record for the platform landing scanner.
// Optional head-bump detection is enabled with the COLLIDE_CEIL_EN macro.
package plat_pkg;

  localparam int PLAT_NUM  = 7;
  localparam int PHY_WIDTH = 16;
  localparam int LEN_WIDTH = 4;
  localparam int TILE_W    = 16;
  localparam int PLAT_H    = 8;
  localparam int PLAYER_W  = 32;

  localparam int IDX_W = $clog2(PLAT_NUM);
  // One extra bit so top/right/hitbox-right never wrap.
  localparam int EXT_W = PHY_WIDTH + 1;

  typedef logic [PHY_WIDTH-1:0] coord_t;
  typedef logic [EXT_W-1:0]     ext_t;
  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [LEN_WIDTH-1:0] len_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic   hit;
    idx_t   hit_idx;
    coord_t land_y;
    logic   ceil_hit;
    idx_t   ceil_idx;
  } result_t;

endpackage

// File: rtl/plat_collide_scan_if.sv
// Request/response bundle between the physics tick controller and the landing scanner.
// Platform tables travel here too since they are read live during the scan.
interface plat_collide_scan_if;
  import plat_pkg::*;

  logic                          start;
  logic                          block_switch;
  coord_t                        player_x;
  coord_t                        player_y;
  coord_t                        player_prev_y;
  logic [PLAT_NUM*PHY_WIDTH-1:0] plat_x;
  logic [PLAT_NUM*PHY_WIDTH-1:0] plat_y;
  logic [PLAT_NUM*LEN_WIDTH-1:0] plat_len;

  logic                          busy;
  logic                          result_valid;
  logic                          hit;
  idx_t                          hit_idx;
  coord_t                        land_y;
  logic                          ceil_hit;
  idx_t                          ceil_idx;

  modport master (
    output start, block_switch, player_x, player_y, player_prev_y,
           plat_x, plat_y, plat_len,
    input  busy, result_valid, hit, hit_idx, land_y, ceil_hit, ceil_idx
  );

  modport slave (
    input  start, block_switch, player_x, player_y, player_prev_y,
           plat_x, plat_y, plat_len,
    output busy, result_valid, hit, hit_idx, land_y, ceil_hit, ceil_idx
  );

endinterface

// File: rtl/plat_collide_scan_hit_check.sv
// Combinational test of one platform against the player's foot/head motion.
// The head-bump output exists only when COLLIDE_CEIL_EN is defined.
module plat_hit_check
  import plat_pkg::*;
(
  input  coord_t px,
  input  coord_t py,
  input  coord_t pprev,
  input  coord_t x,
  input  coord_t y,
  input  len_t   len,
  output logic   hit,
  output ext_t   top
`ifdef COLLIDE_CEIL_EN
  ,
  output logic   ceil
`endif
);

  ext_t right, pl, pr;
  logic occupied, x_ovl;

  assign occupied = |len;
  assign top      = ext_t'(y) + ext_t'(PLAT_H);
  assign right    = ext_t'(x) + ext_t'(len) * ext_t'(TILE_W);
  assign pl       = ext_t'(px);
  assign pr       = pl + ext_t'(PLAYER_W);
  assign x_ovl    = (pr > ext_t'(x)) && (pl < right);

  // Crossing the top from above or resting on it; a rising player can never satisfy both bounds.
  assign hit = occupied && x_ovl && (ext_t'(pprev) >= top) && (ext_t'(py) <= top);

`ifdef COLLIDE_CEIL_EN
  ext_t head, prev_head;
  assign head      = ext_t'(py) + ext_t'(PLAYER_W);
  assign prev_head = ext_t'(pprev) + ext_t'(PLAYER_W);
  assign ceil = occupied && x_ovl && (py > pprev) &&
                (prev_head <= ext_t'(y)) && (head >= ext_t'(y));
`endif

endmodule

// File: rtl/plat_collide_scan.sv
// Serial landing scanner: one platform per cycle, reports the highest platform landed on.
// Define COLLIDE_CEIL_EN to also report the lowest platform bumped while rising.
module plat_collide_scan
  import plat_pkg::*;
(
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  plat_collide_scan_if.slave bus
);

  state_t  state, state_n;
  idx_t    idx;
  coord_t  px_q, py_q, pprev_q;
  logic    accept, finish;

  coord_t  cur_x, cur_y;
  len_t    cur_len;
  logic    chk_hit;
  ext_t    chk_top;

  logic    best_hit;
  idx_t    best_idx;
  ext_t    best_top;

  result_t res_q;
  logic    rv_q;

  // Tables are not latched; the slot under test is picked live by idx.
  assign cur_x   = bus.plat_x[int'(idx)*PHY_WIDTH +: PHY_WIDTH];
  assign cur_y   = bus.plat_y[int'(idx)*PHY_WIDTH +: PHY_WIDTH];
  assign cur_len = bus.plat_len[int'(idx)*LEN_WIDTH +: LEN_WIDTH];

`ifdef COLLIDE_CEIL_EN
  logic   chk_ceil;
  logic   best_ceil;
  idx_t   best_cidx;
  coord_t best_cy;
`endif

  plat_hit_check u_chk (
    .px    (px_q),
    .py    (py_q),
    .pprev (pprev_q),
    .x     (cur_x),
    .y     (cur_y),
    .len   (cur_len),
    .hit   (chk_hit),
    .top   (chk_top)
`ifdef COLLIDE_CEIL_EN
    ,
    .ceil  (chk_ceil)
`endif
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start && !bus.block_switch) begin
          state_n = S_SCAN;
          accept  = 1'b1;
        end
      end
      S_SCAN: begin
        if (bus.block_switch)                   state_n = S_IDLE;
        else if (idx == idx_t'(PLAT_NUM - 1))   state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
        finish  = !bus.block_switch;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx      <= '0;
      px_q     <= '0;
      py_q     <= '0;
      pprev_q  <= '0;
      best_hit <= 1'b0;
      best_idx <= '0;
      best_top <= '0;
      res_q    <= '0;
      rv_q     <= 1'b0;
`ifdef COLLIDE_CEIL_EN
      best_ceil <= 1'b0;
      best_cidx <= '0;
      best_cy   <= '0;
`endif
    end else begin
      rv_q <= finish;
      if (accept) begin
        idx      <= '0;
        px_q     <= bus.player_x;
        py_q     <= bus.player_y;
        pprev_q  <= bus.player_prev_y;
        best_hit <= 1'b0;
        best_idx <= '0;
        best_top <= '0;
`ifdef COLLIDE_CEIL_EN
        best_ceil <= 1'b0;
        best_cidx <= '0;
        best_cy   <= '0;
`endif
      end else if (state == S_SCAN) begin
        idx <= idx + 1'b1;
        // Strict compares keep the lower index on ties.
        if (chk_hit && (!best_hit || chk_top > best_top)) begin
          best_hit <= 1'b1;
          best_idx <= idx;
          best_top <= chk_top;
        end
`ifdef COLLIDE_CEIL_EN
        if (chk_ceil && (!best_ceil || cur_y < best_cy)) begin
          best_ceil <= 1'b1;
          best_cidx <= idx;
          best_cy   <= cur_y;
        end
`endif
      end
      if (finish) begin
        res_q.hit     <= best_hit;
        res_q.hit_idx <= best_idx;
        res_q.land_y  <= best_top[PHY_WIDTH-1:0];
`ifdef COLLIDE_CEIL_EN
        res_q.ceil_hit <= best_ceil;
        res_q.ceil_idx <= best_cidx;
`else
        res_q.ceil_hit <= 1'b0;
        res_q.ceil_idx <= '0;
`endif
      end
    end
  end

  assign bus.busy         = (state != S_IDLE);
  assign bus.result_valid = rv_q;
  assign bus.hit          = res_q.hit;
  assign bus.hit_idx      = res_q.hit_idx;
  assign bus.land_y       = res_q.land_y;
  assign bus.ceil_hit     = res_q.ceil_hit;
  assign bus.ceil_idx     = res_q.ceil_idx;

endmodule

// File: tb/tb_plat_collide_scan.sv
// Scoreboard bench for plat_collide_scan: directed scans push expectations, a monitor checks results.
// Head-bump expectations follow COLLIDE_CEIL_EN.
module tb_plat_collide_scan;
  import plat_pkg::*;

`ifdef COLLIDE_CEIL_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  plat_collide_scan_if bus();

  plat_collide_scan dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  typedef struct {
    int hit;
    int idx;
    int land;
    int ceil;
    int cidx;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (sys_rst_n && bus.result_valid) begin
      if (sb.size() == 0) begin
        check("spurious_result_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("latency_cycle", cyc, e.cyc);
        check("hit", bus.hit, e.hit);
        if (e.hit != 0) begin
          check("hit_idx", bus.hit_idx, e.idx);
          check("land_y", bus.land_y, e.land);
        end
        check("ceil_hit", bus.ceil_hit, e.ceil);
        if (e.ceil != 0) check("ceil_idx", bus.ceil_idx, e.cidx);
        check("busy_at_result", bus.busy, 0);
      end
    end
  end

  task automatic clear_tables();
    bus.plat_x   = '0;
    bus.plat_y   = '0;
    bus.plat_len = '0;
  endtask

  task automatic slot(input int i, input int x, input int y, input int len);
    bus.plat_x[i*PHY_WIDTH +: PHY_WIDTH]   = coord_t'(x);
    bus.plat_y[i*PHY_WIDTH +: PHY_WIDTH]   = coord_t'(y);
    bus.plat_len[i*LEN_WIDTH +: LEN_WIDTH] = len_t'(len);
  endtask

  task automatic set_player(input int px, input int py, input int pprev);
    bus.player_x      = coord_t'(px);
    bus.player_y      = coord_t'(py);
    bus.player_prev_y = coord_t'(pprev);
  endtask

  // Issue one scan and wait long enough for its result; a missing result counts as a failure.
  task automatic run(input string name, input int px, input int py, input int pprev,
                     input int eh, input int ei, input int el, input int ec, input int eci);
    exp_t e;
    @(negedge sys_clk);
    set_player(px, py, pprev);
    bus.start = 1'b1;
    e.hit = eh; e.idx = ei; e.land = el; e.ceil = ec; e.cidx = eci;
    e.cyc = cyc + 9;
    sb.push_back(e);
    @(negedge sys_clk);
    bus.start = 1'b0;
    check({name, "_busy"}, bus.busy, 1);
    repeat (9) @(negedge sys_clk);
    check({name, "_result_seen"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bus.start        = 1'b0;
    bus.block_switch = 1'b0;
    set_player(0, 0, 0);
    clear_tables();

    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_fields", {bus.hit, bus.hit_idx, bus.land_y, bus.ceil_hit, bus.ceil_idx}, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Single platform in slot 1: x 100..227, top 108.
    slot(1, 100, 100, 8);
    run("basic",       120, 104, 112, 1, 1, 108, 0, 0);
    run("right_out",   228, 104, 112, 0, 0, 0,   0, 0);
    run("right_in",    227, 104, 112, 1, 1, 108, 0, 0);
    run("left_in",      69, 104, 112, 1, 1, 108, 0, 0);
    run("left_out",     68, 104, 112, 0, 0, 0,   0, 0);
    run("standing",    120, 108, 108, 1, 1, 108, 0, 0);
    run("prev_below",  120, 104, 107, 0, 0, 0,   0, 0);
    run("still_above", 120, 109, 112, 0, 0, 0,   0, 0);

    // Two overlapping candidates: highest top wins, ties go to the lower index.
    clear_tables();
    slot(2, 100, 132, 8);
    slot(5, 100, 100, 8);
    run("two_low_idx_high", 120, 100, 150, 1, 2, 140, 0, 0);
    slot(2, 100, 100, 8);
    slot(5, 100, 132, 8);
    run("two_high_idx_high", 120, 100, 150, 1, 5, 140, 0, 0);
    slot(5, 100, 100, 8);
    run("two_tie", 120, 100, 150, 1, 2, 108, 0, 0);

    clear_tables();
    slot(3, 100, 100, 0);
    run("empty_slot", 120, 104, 112, 0, 0, 0, 0, 0);

    // block_switch on the third SCAN cycle aborts without a result.
    clear_tables();
    slot(1, 100, 100, 8);
    @(negedge sys_clk);
    set_player(120, 104, 112);
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    bus.block_switch = 1'b1;
    @(negedge sys_clk);
    bus.block_switch = 1'b0;
    check("abort_busy", bus.busy, 0);
    repeat (10) @(negedge sys_clk);
    run("after_abort", 120, 104, 112, 1, 1, 108, 0, 0);

    // A second start mid-scan must not produce a second result.
    @(negedge sys_clk);
    set_player(120, 104, 112);
    bus.start = 1'b1;
    e.hit = 1; e.idx = 1; e.land = 108; e.ceil = 0; e.cidx = 0;
    e.cyc = cyc + 9;
    sb.push_back(e);
    @(negedge sys_clk);
    bus.start = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    set_player(68, 104, 112);
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    repeat (16) @(negedge sys_clk);
    check("double_start_result_seen", sb.size(), 0);
    sb.delete();

    // block_switch together with start in IDLE: start is dropped.
    @(negedge sys_clk);
    bus.start        = 1'b1;
    bus.block_switch = 1'b1;
    @(negedge sys_clk);
    bus.start        = 1'b0;
    bus.block_switch = 1'b0;
    check("switch_start_busy", bus.busy, 0);
    repeat (10) @(negedge sys_clk);

    // Head bump: rising, head 190 -> 205 against plat_y 200; landing impossible.
    clear_tables();
    slot(0, 100, 200, 8);
    run("ceil_basic", 120, 173, 158, 0, 0, 0, CE, 0);
    slot(4, 100, 195, 8);
    run("ceil_lowest", 120, 173, 158, 0, 0, 0, CE, 4);
    slot(4, 100, 200, 8);
    run("ceil_tie", 120, 173, 158, 0, 0, 0, CE, 0);

    // Reset mid-scan after a hit result clears everything.
    clear_tables();
    slot(1, 100, 100, 8);
    run("pre_reset", 120, 104, 112, 1, 1, 108, 0, 0);
    @(negedge sys_clk);
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("midreset_busy", bus.busy, 0);
    check("midreset_result_valid", bus.result_valid, 0);
    check("midreset_hit", bus.hit, 0);
    check("midreset_fields", {bus.hit_idx, bus.land_y, bus.ceil_hit, bus.ceil_idx}, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (12) @(negedge sys_clk);
    run("post_reset", 120, 104, 112, 1, 1, 108, 0, 0);

    repeat (5) @(negedge sys_clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
